// File: rtl/softreg_cmd_seq.sv
// softreg_cmd_seq: replays a programmable table of SoftReg requests into an accelerator, then waits for completion
module softreg_cmd_seq #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 0,
  parameter int IDX_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_is_write,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W-1:0]  cfg_len,
  input  logic [7:0]        cfg_gap,
  input  logic [7:0]        cfg_resp_expect,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [DATA_W-1:0] resp_last_data,
  output logic [31:0]       run_cycles,
  output logic              softreg_req_valid,
  output logic              softreg_req_isWrite,
  output logic [ADDR_W-1:0] softreg_req_addr,
  output logic [DATA_W-1:0] softreg_req_data,
  input  logic              softreg_resp_valid,
  input  logic [DATA_W-1:0] softreg_resp_data
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, len_q, len_d, len_clamp, ptr_inc;
  logic [7:0]        gap_q, gap_d, gcnt_q, gcnt_d, exp_q, exp_d, rcnt_q, rcnt_d;
  logic [31:0]       wait_q, wait_d, run_q, run_d;
  logic              done_q, done_d, to_q, to_d, req_valid_q, req_valid_d;
  logic [DATA_W-1:0] rlast_q, rlast_d;
  logic [EW-1:0]     req_q, req_d, entry_n, cfg_entry;
  logic [EW-1:0]     tbl_q [DEPTH];
  logic              ready, active, go, wr, complete;
  assign ready     = state_q == S_IDLE || state_q == S_DONE;
  assign active    = state_q == S_ISSUE || state_q == S_GAP || state_q == S_WAIT;
  assign go        = start && ready;
  assign wr        = cfg_we && ready && cfg_idx < DEPTH_L;
  assign cfg_entry = {cfg_is_write, cfg_addr, cfg_data};
  assign len_clamp = cfg_len > DEPTH_L ? DEPTH_L : cfg_len;
  assign ptr_inc   = ptr_q + 1'b1;
  assign complete  = {1'b0, rcnt_q} + {8'd0, softreg_resp_valid} >= {1'b0, exp_q};
  // Run sequencing: latch the run setup on start, walk the table with gaps, then wait for responses or timeout
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    exp_d   = exp_q;
    gcnt_d  = gcnt_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) begin
        len_d   = len_clamp;
        gap_d   = cfg_gap;
        exp_d   = cfg_resp_expect;
        ptr_d   = '0;
        wait_d  = 32'd0;
        to_d    = 1'b0;
        state_d = len_clamp != '0 ? S_ISSUE : S_WAIT;
      end
      S_ISSUE: begin
        ptr_d   = ptr_inc;
        gcnt_d  = 8'd0;
        wait_d  = 32'd0;
        state_d = ptr_inc == len_q ? S_WAIT : gap_q != 8'd0 ? S_GAP : S_ISSUE;
      end
      S_GAP: begin
        gcnt_d  = gcnt_q + 8'd1;
        state_d = gcnt_q == gap_q - 8'd1 ? S_ISSUE : S_GAP;
      end
      S_WAIT: begin
        wait_d  = wait_q + 32'd1;
        done_d  = complete;
        to_d    = !complete && TIMEOUT > 0 && wait_q == 32'(TIMEOUT - 1);
        state_d = complete || to_d ? S_DONE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Request and status datapath; a table write on the start cycle is forwarded so entry 0 sees it
  always_comb begin
    entry_n     = wr && cfg_idx == ptr_d ? cfg_entry : tbl_q[ptr_d[AW-1:0]];
    req_valid_d = state_d == S_ISSUE;
    req_d       = req_valid_d ? entry_n : '0;
    rcnt_d      = go ? 8'd0 : active && softreg_resp_valid && rcnt_q != 8'hff ? rcnt_q + 8'd1 : rcnt_q;
    rlast_d     = active && softreg_resp_valid ? softreg_resp_data : rlast_q;
    run_d       = go ? 32'd0 : active && run_q != 32'hffff_ffff ? run_q + 32'd1 : run_q;
  end
  // Control and output registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      gap_q       <= 8'd0;
      exp_q       <= 8'd0;
      gcnt_q      <= 8'd0;
      rcnt_q      <= 8'd0;
      wait_q      <= 32'd0;
      run_q       <= 32'd0;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      rlast_q     <= '0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      exp_q       <= exp_d;
      gcnt_q      <= gcnt_d;
      rcnt_q      <= rcnt_d;
      wait_q      <= wait_d;
      run_q       <= run_d;
      done_q      <= done_d;
      to_q        <= to_d;
      rlast_q     <= rlast_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
    end
  end
  // Command table storage; contents survive reset so a run can be replayed
  always_ff @(posedge clk) begin
    if (wr) tbl_q[cfg_idx[AW-1:0]] <= cfg_entry;
  end
  assign busy              = active;
  assign done              = done_q;
  assign timed_out         = to_q;
  assign resp_last_data    = rlast_q;
  assign run_cycles        = run_q;
  assign softreg_req_valid = req_valid_q;
  assign {softreg_req_isWrite, softreg_req_addr, softreg_req_data} = req_q;
endmodule

// File: tb/tb_softreg_cmd_seq.sv
// tb_softreg_cmd_seq: directed self-checking bench for the SoftReg command sequencer
module tb_softreg_cmd_seq;
  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [63:0] T1D [9] = '{64'd1001, 64'd16000, 64'h1000, 64'h2000, 64'h3000,
                                      64'h4000, 64'd85, 64'd10, 64'd0};
  logic clk = 1'b0, rst = 1'b0;
  logic cfg_we = 1'b0, cfg_is_write = 1'b0, start = 1'b0, start_to = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0, cfg_len = '0;
  logic [31:0] cfg_addr = '0;
  logic [63:0] cfg_data = '0, resp_data = '0;
  logic [7:0] cfg_gap = '0, cfg_exp = '0;
  logic resp_valid = 1'b0;
  logic busy, done, timed_out, req_valid, req_w;
  logic [63:0] resp_last, req_d;
  logic [31:0] run, req_a;
  logic to_busy, to_done, to_timed_out, to_req_valid, to_req_w;
  logic [63:0] to_resp_last, to_req_d;
  logic [31:0] to_run, to_req_a;
  int checks = 0, errors = 0;
  int nv, dn, nz;
  logic [6:0] pat;
  always #5 clk = ~clk;
  softreg_cmd_seq #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_is_write(cfg_is_write),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .cfg_resp_expect(cfg_exp), .start(start), .busy(busy), .done(done), .timed_out(timed_out),
    .resp_last_data(resp_last), .run_cycles(run), .softreg_req_valid(req_valid),
    .softreg_req_isWrite(req_w), .softreg_req_addr(req_a), .softreg_req_data(req_d),
    .softreg_resp_valid(resp_valid), .softreg_resp_data(resp_data));
  softreg_cmd_seq #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64), .TIMEOUT(20)) u_to (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_is_write(cfg_is_write),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .cfg_resp_expect(cfg_exp), .start(start_to), .busy(to_busy), .done(to_done),
    .timed_out(to_timed_out), .resp_last_data(to_resp_last), .run_cycles(to_run),
    .softreg_req_valid(to_req_valid), .softreg_req_isWrite(to_req_w), .softreg_req_addr(to_req_a),
    .softreg_req_data(to_req_d), .softreg_resp_valid(resp_valid), .softreg_resp_data(resp_data));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr_ent(input logic [IDX_W-1:0] idx, input logic w, input logic [31:0] a, input logic [63:0] d);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_is_write = w;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask
  task automatic go(input logic [IDX_W-1:0] len, input logic [7:0] gap, input logic [7:0] exp);
    cfg_len = len;
    cfg_gap = gap;
    cfg_exp = exp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timed_out, 0);
    chk("rst_valid", req_valid, 0);
    chk("rst_run", run, 0);
    chk("rst_last", resp_last, 0);
    rst = 1'b1;
    step();
    // T1: nine back-to-back parameter writes, response 40 cycles after the last one
    for (int k = 0; k < 9; k++) wr_ent(IDX_W'(k), 1'b1, 32'(8 * k), T1D[k]);
    go(9, 0, 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      chk("t1_valid", req_valid, 1);
      chk("t1_wr", req_w, 1);
      chk("t1_addr", req_a, 64'(8 * k));
      chk("t1_data", req_d, T1D[k]);
    end
    nv = 0;
    dn = 0;
    nz = 0;
    for (int c = 10; c <= 49; c++) begin
      step();
      nv += int'(req_valid);
      dn |= int'(done);
      nz |= int'(|{req_w, req_a, req_d});
    end
    chk("t1_idle_valid", nv, 0);
    chk("t1_idle_fields", nz, 0);
    chk("t1_early_done", dn, 0);
    chk("t1_busy_wait", busy, 1);
    resp_valid = 1'b1;
    resp_data = 64'd1;
    step();
    resp_valid = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_run", run, 49);
    chk("t1_last", resp_last, 1);
    chk("t1_to", timed_out, 0);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_run_hold", run, 49);
    // T2: three entries with gap 2, expect 0
    go(3, 2, 0);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step();
      pat[c-1] = req_valid;
      if (req_valid) chk("t2_addr", req_a, 64'(8 * ((c - 1) / 3)));
    end
    chk("t2_pattern", pat, 7'b1001001);
    step();
    chk("t2_wait_valid", req_valid, 0);
    chk("t2_wait_busy", busy, 1);
    chk("t2_wait_done", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_run", run, 8);
    // T3: timeout instance, one request and no response
    cfg_len = 1;
    cfg_gap = 0;
    cfg_exp = 1;
    start_to = 1'b1;
    step();
    start_to = 1'b0;
    chk("t3_valid", to_req_valid, 1);
    chk("t3_busy", to_busy, 1);
    dn = 0;
    for (int c = 2; c <= 21; c++) begin
      step();
      dn |= int'(to_done);
    end
    chk("t3_busy_last", to_busy, 1);
    chk("t3_to_early", to_timed_out, 0);
    step();
    dn |= int'(to_done);
    chk("t3_to", to_timed_out, 1);
    chk("t3_busy_end", to_busy, 0);
    chk("t3_no_done", dn, 0);
    chk("t3_run", to_run, 21);
    step();
    chk("t3_to_sticky", to_timed_out, 1);
    chk("t3_done_after", to_done, 0);
    // T4: response during a gap counts toward completion
    go(4, 3, 1);
    chk("t4_valid0", req_valid, 1);
    step();
    resp_valid = 1'b1;
    resp_data = 64'hABC;
    step();
    resp_valid = 1'b0;
    chk("t4_last", resp_last, 64'hABC);
    chk("t4_gap_valid", req_valid, 0);
    chk("t4_busy", busy, 1);
    nv = 0;
    for (int c = 4; c <= 13; c++) begin
      step();
      nv += int'(req_valid);
    end
    chk("t4_nv", nv, 3);
    chk("t4_last_valid", req_valid, 1);
    chk("t4_last_addr", req_a, 24);
    step();
    chk("t4_wait_valid", req_valid, 0);
    chk("t4_wait_done", done, 0);
    step();
    chk("t4_done", done, 1);
    chk("t4_busy_end", busy, 0);
    chk("t4_run", run, 14);
    // T5: full table, over-long length, out-of-range write, writes/start while busy
    for (int i = 0; i < DEPTH; i++) wr_ent(IDX_W'(i), 1'((i + 1) % 2), 32'h100 + 32'(4 * i), 64'hD0 + 64'(i));
    wr_ent(IDX_W'(DEPTH), 1'b1, 32'hBAD, 64'hBAD);
    go(IDX_W'(DEPTH + 5), 0, 0);
    nv = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) step();
      if (c == 4) begin
        cfg_we = 1'b0;
        start = 1'b0;
      end
      nv += int'(req_valid);
      if (c <= 16) begin
        chk("t5_addr", req_a, 64'h100 + 64'(4 * (c - 1)));
        chk("t5_data", req_d, 64'hD0 + 64'(c - 1));
        chk("t5_wr", req_w, 64'(c % 2));
      end
      if (c == 3) begin
        cfg_we = 1'b1;
        cfg_idx = 5;
        cfg_addr = 32'hEEE;
        cfg_data = 64'hEEE;
        start = 1'b1;
      end
    end
    chk("t5_nv", nv, DEPTH);
    chk("t5_wait_busy", busy, 1);
    step();
    chk("t5_done", done, 1);
    chk("t5_run", run, 17);
    // T6: write-with-start forwarding, mid-run reset, replay
    cfg_we = 1'b1;
    cfg_idx = 0;
    cfg_is_write = 1'b1;
    cfg_addr = 32'h777;
    cfg_data = 64'h5A5A;
    go(5, 0, 1);
    cfg_we = 1'b0;
    chk("t6_fwd_addr", req_a, 64'h777);
    chk("t6_fwd_data", req_d, 64'h5A5A);
    step();
    chk("t6_second", req_a, 64'h104);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_rst_valid", req_valid, 0);
    chk("t6_rst_addr", req_a, 0);
    chk("t6_rst_data", req_d, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_run", run, 0);
    chk("t6_rst_last", resp_last, 0);
    chk("t6_rst_to", to_timed_out, 0);
    nv = 0;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      nv += int'(req_valid);
      dn |= int'(done);
    end
    chk("t6_quiet", nv, 0);
    chk("t6_no_done", dn, 0);
    go(5, 0, 1);
    chk("t6_replay0", req_a, 64'h777);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("t6_replay", req_a, 64'h100 + 64'(4 * (c - 1)));
    end
    step();
    chk("t6_wait_valid", req_valid, 0);
    resp_valid = 1'b1;
    resp_data = 64'h99;
    step();
    resp_valid = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_run", run, 6);
    chk("t6_last", resp_last, 64'h99);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
